// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory request/response channel and the decoder-facing
// instruction channel of the fetch stage.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// In-order instruction fetch with a credit-limited request stream, a small {pc,data} FIFO
// and redirect flushing. Optional FETCH_MISALIGN_TRAP_EN adds a sticky misaligned-target fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic         fetch_fault
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   buf_pc   [FIFO_DEPTH];
  logic [31:0]   buf_data [FIFO_DEPTH];
  logic [31:0]   target;
  logic          fault;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp;
  logic          push;
  logic          pop;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  assign target      = redirect_pc;
  assign misaligned  = redirect_pc[1:0] != 2'b00;
  assign fetch_fault = fault & ~rst;
`else
  assign target = redirect_pc & ~32'h3;
  assign fault  = 1'b0;
`endif

  // Credits cover both in-flight requests and buffered words, so responses always have room.
  assign credit_ok          = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_W;
  assign bus.imem_req_valid = ~rst & ~redirect_valid & ~fault & credit_ok;
  assign bus.imem_req_addr  = pc;
  assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp                = bus.imem_rsp_valid;
  assign push               = rsp & ~redirect_valid & (drop_cnt == '0);
  assign pop                = (count != '0) & bus.instr_ready & ~redirect_valid;

  assign bus.instr_valid = ~rst & (count != '0);
  assign bus.instr       = bus.instr_valid ? buf_data[rd_ptr] : '0;
  assign bus.instr_pc    = bus.instr_valid ? buf_pc[rd_ptr]   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault       <= 1'b0;
`endif
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp);
      if (redirect_valid) begin
        // Everything still in flight after this cycle's response belongs to the old stream.
        pc       <= target;
        resp_pc  <= target;
        drop_cnt <= outstanding - CW'(rsp);
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault    <= misaligned;
`endif
      end else begin
        if (req_fire)
          pc <= pc + 32'd4;
        if (rsp && drop_cnt != '0)
          drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + PW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= resp_pc;
      buf_data[wr_ptr] <= bus.imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-programmable in-order memory model and
// a PC-stream scoreboard derived from the fetch rules (sequential words, redirect restarts).
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  int          mem_lat        = 1;
  bit          mem_rand_ready = 1'b0;
  int          cyc            = 0;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  // Memory drives its outputs just after each rising edge, in order, one response per cycle.
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.imem_req_ready = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.imem_rsp_valid = (pend_addr.size() != 0) && (pend_due[0] <= cyc);
      bus.imem_rsp_data  = bus.imem_rsp_valid ? mem_word(pend_addr[0]) : 32'hDEAD_BEEF;
      bus.imem_req_ready = mem_rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
      end else begin
        if (bus.imem_rsp_valid) begin
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          pend_addr.push_back(bus.imem_req_addr);
          pend_due.push_back(cyc + mem_lat);
        end
      end
    end
  end

  task automatic applyStimulus(input bit r, input bit rdy, input bit redir, input logic [31:0] rpc);
    @(posedge clk);
    #2;
    rst             = r;
    bus.instr_ready = rdy;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    @(negedge clk);
  endtask

  task automatic test_reset;
    mem_lat = 1;
    mem_rand_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (bus.imem_req_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid);
      end
      n_cmp++;
      if (bus.instr_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_instr_valid: got %b expected 0", bus.instr_valid);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      n_cmp++;
      if (fetch_fault !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_fault: got %b expected 0", fetch_fault);
      end
`endif
    end
    n_cmp++;
    if (bus.imem_req_addr !== RESET_PC) begin
      n_fail++;
      $display("[TB] FAIL reset_addr: got %h expected %h", bus.imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_first_fetch;
    int first_acc = -1;
    int first_val = -1;
    logic [31:0] exp_req = RESET_PC;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (first_acc < 0) first_acc = i;
        n_cmp++;
        if (bus.imem_req_addr !== exp_req) begin
          n_fail++;
          $display("[TB] FAIL first_req_addr: got %h expected %h", bus.imem_req_addr, exp_req);
        end
        exp_req += 32'd4;
      end
      if (bus.instr_valid && first_val < 0) begin
        first_val = i;
        n_cmp++;
        if (bus.instr_pc !== RESET_PC || bus.instr !== mem_word(RESET_PC)) begin
          n_fail++;
          $display("[TB] FAIL first_instr: got pc %h instr %h expected pc %h instr %h",
                   bus.instr_pc, bus.instr, RESET_PC, mem_word(RESET_PC));
        end
      end
    end
    n_cmp++;
    if (first_acc < 0 || first_val < 0 || (first_val - first_acc) != 2) begin
      n_fail++;
      $display("[TB] FAIL first_latency: got accept %0d valid %0d expected gap 2", first_acc, first_val);
    end
  endtask

  task automatic test_stall;
    int acc = 0;
    int pops = 0;
    logic [31:0] exp_pc = 32'h40;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      if (bus.imem_req_valid && bus.imem_req_ready) acc++;
      if (bus.instr_valid) begin
        n_cmp++;
        if (bus.instr_pc !== 32'h40 || bus.instr !== mem_word(32'h40)) begin
          n_fail++;
          $display("[TB] FAIL stall_head: got pc %h instr %h expected pc 00000040", bus.instr_pc, bus.instr);
        end
      end
    end
    n_cmp++;
    if (acc != DEPTH || bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL stall_full: got accepts %0d req_valid %b instr_valid %b expected %0d 0 1",
               acc, bus.imem_req_valid, bus.instr_valid, DEPTH);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      if (bus.instr_valid) begin
        pops++;
        n_cmp++;
        if (bus.instr_pc !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
          n_fail++;
          $display("[TB] FAIL stall_drain: got pc %h instr %h expected pc %h", bus.instr_pc, bus.instr, exp_pc);
        end
        exp_pc += 32'd4;
      end
    end
    n_cmp++;
    if (pops < 4) begin
      n_fail++;
      $display("[TB] FAIL stall_drain_count: got %0d expected at least 4", pops);
    end
  endtask

  task automatic test_redirect_inflight;
    int acc = 0;
    bit seen_val = 1'b0;
    bit seen_req = 1'b0;
    mem_lat = 3;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      if (bus.imem_req_valid && bus.imem_req_ready) acc++;
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
    n_cmp++;
    if (acc != 2 || bus.imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL inflight_setup: got accepts %0d req_valid %b expected 2 0", acc, bus.imem_req_valid);
    end
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      if (bus.imem_req_valid && bus.imem_req_ready && !seen_req) begin
        seen_req = 1'b1;
        n_cmp++;
        if (bus.imem_req_addr !== 32'h100) begin
          n_fail++;
          $display("[TB] FAIL inflight_req: got %h expected 00000100", bus.imem_req_addr);
        end
      end
      if (bus.instr_valid && !seen_val) begin
        seen_val = 1'b1;
        n_cmp++;
        if (bus.instr_pc !== 32'h100 || bus.instr !== mem_word(32'h100)) begin
          n_fail++;
          $display("[TB] FAIL inflight_instr: got pc %h instr %h expected pc 00000100", bus.instr_pc, bus.instr);
        end
      end
    end
    n_cmp++;
    if (!seen_val) begin
      n_fail++;
      $display("[TB] FAIL inflight_timeout: got no instr_valid expected one");
    end
  endtask

  task automatic test_redirect_collision;
    bit found = 1'b0;
    mem_lat = 1;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk);
      #2;
      found           = bus.imem_rsp_valid && bus.instr_valid;
      rst             = 1'b0;
      bus.instr_ready = 1'b1;
      redirect_valid  = found;
      redirect_pc     = 32'h200;
      @(negedge clk);
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL collision_timeout: got no rsp/instr overlap expected one");
    end else begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (bus.instr_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL collision_flush: got instr_valid %b expected 0", bus.instr_valid);
      end
      n_cmp++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin
        n_fail++;
        $display("[TB] FAIL collision_req: got valid %b addr %h expected 1 00000200",
                 bus.imem_req_valid, bus.imem_req_addr);
      end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_pc = 32'hFFFF_FFF8;
    int pops = 0;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      if (bus.instr_valid) begin
        pops++;
        n_cmp++;
        if (bus.instr_pc !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
          n_fail++;
          $display("[TB] FAIL wrap_pc: got pc %h instr %h expected pc %h", bus.instr_pc, bus.instr, exp_pc);
        end
        exp_pc += 32'd4;
      end
    end
    n_cmp++;
    if (pops < 4) begin
      n_fail++;
      $display("[TB] FAIL wrap_count: got %0d expected at least 4", pops);
    end
  endtask

  task automatic test_reset_midstream;
    bit seen_req = 1'b0;
    bit seen_val = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (bus.instr_valid !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midrst_full: got instr_valid %b req_valid %b expected 1 0",
               bus.instr_valid, bus.imem_req_valid);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== RESET_PC || bus.instr_valid !== 1'b0 ||
        bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL midrst_outputs: got %b %h %b %h %h expected 0 %h 0 0 0", bus.imem_req_valid,
               bus.imem_req_addr, bus.instr_valid, bus.instr, bus.instr_pc, RESET_PC);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      if (bus.imem_req_valid && bus.imem_req_ready && !seen_req) begin
        seen_req = 1'b1;
        n_cmp++;
        if (bus.imem_req_addr !== RESET_PC) begin
          n_fail++;
          $display("[TB] FAIL midrst_req: got %h expected %h", bus.imem_req_addr, RESET_PC);
        end
      end
      if (bus.instr_valid && !seen_val) begin
        seen_val = 1'b1;
        n_cmp++;
        if (bus.instr_pc !== RESET_PC) begin
          n_fail++;
          $display("[TB] FAIL midrst_instr: got %h expected %h", bus.instr_pc, RESET_PC);
        end
      end
    end
  endtask

`ifdef FETCH_MISALIGN_TRAP_EN
  task automatic test_misalign;
    bit seen_req = 1'b0;
    bit seen_val = 1'b0;
    mem_lat = 1;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h102);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (fetch_fault !== 1'b1 || bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL misalign_hold: got fault %b req %b instr %b expected 1 0 0",
                 fetch_fault, bus.imem_req_valid, bus.instr_valid);
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (fetch_fault !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL misalign_clear: got %b expected 0", fetch_fault);
      end
      if (bus.imem_req_valid && bus.imem_req_ready && !seen_req) begin
        seen_req = 1'b1;
        n_cmp++;
        if (bus.imem_req_addr !== 32'h200) begin
          n_fail++;
          $display("[TB] FAIL misalign_req: got %h expected 00000200", bus.imem_req_addr);
        end
      end
      if (bus.instr_valid && !seen_val) begin
        seen_val = 1'b1;
        n_cmp++;
        if (bus.instr_pc !== 32'h200) begin
          n_fail++;
          $display("[TB] FAIL misalign_instr: got %h expected 00000200", bus.instr_pc);
        end
      end
    end
  endtask
`endif

  // Random traffic: the expected instruction and request streams are simply
  // consecutive words from the last redirect target.
  task automatic test_random;
    logic [31:0] exp_pc  = 32'h1000;
    logic [31:0] exp_req = 32'h1000;
    logic [31:0] rpc;
    bit rdy;
    bit redir;
    int pops = 0;
    mem_rand_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h1000);
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 0) mem_lat = $urandom_range(1, 3);
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 24) == 0);
      rpc   = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      rpc[1:0] = 2'b00;
`endif
      applyStimulus(1'b0, rdy, redir, rpc);
      if (redir) begin
        n_cmp++;
        if (bus.imem_req_valid !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL rand_redir_req: got %b expected 0", bus.imem_req_valid);
        end
        exp_pc  = rpc & ~32'h3;
        exp_req = rpc & ~32'h3;
      end else begin
        if (bus.instr_valid && bus.instr_ready) begin
          pops++;
          n_cmp++;
          if (bus.instr_pc !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
            n_fail++;
            $display("[TB] FAIL rand_instr: got pc %h instr %h expected pc %h instr %h",
                     bus.instr_pc, bus.instr, exp_pc, mem_word(exp_pc));
          end
          exp_pc += 32'd4;
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          n_cmp++;
          if (bus.imem_req_addr !== exp_req) begin
            n_fail++;
            $display("[TB] FAIL rand_req: got %h expected %h", bus.imem_req_addr, exp_req);
          end
          exp_req += 32'd4;
        end
      end
    end
    n_cmp++;
    if (pops < 50) begin
      n_fail++;
      $display("[TB] FAIL rand_progress: got %0d pops expected at least 50", pops);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.instr_ready = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    test_reset;
    test_first_fetch;
    test_stall;
    test_redirect_inflight;
    test_redirect_collision;
    test_wrap;
    test_reset_midstream;
`ifdef FETCH_MISALIGN_TRAP_EN
    test_misalign;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
